// File: rtl/line_memory_ctrl.sv
// Line-granular backing memory: one read/write line request at a time, programmable latency, valid/ready on both sides.
// Define LINE_MEM_PERF_COUNTERS_EN to add non-error read/write completion counters.
module line_memory_ctrl #(
    parameter int LINE_BYTES    = 16,
    parameter int DEPTH_LINES   = 1024,
    parameter int ADDR_W        = 32,
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_req_valid,
    output logic                    out_req_ready,
    input  logic                    in_req_write,
    input  logic [ADDR_W-1:0]       in_req_addr,
    input  logic [LINE_BYTES*8-1:0] in_req_wdata,
    input  logic [LINE_BYTES-1:0]   in_req_byte_en,
    output logic                    out_resp_valid,
    input  logic                    in_resp_ready,
    output logic                    out_resp_write,
    output logic [LINE_BYTES*8-1:0] out_resp_rdata,
    output logic                    out_resp_error
`ifdef LINE_MEM_PERF_COUNTERS_EN
    ,
    output logic [31:0]             out_read_count,
    output logic [31:0]             out_write_count
`endif
);

    localparam int LW      = LINE_BYTES * 8;
    localparam int OFF_W   = $clog2(LINE_BYTES);
    localparam int IDX_W   = $clog2(DEPTH_LINES);
    localparam int TAG_W   = ADDR_W - OFF_W;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic logic [LW-1:0] init_line(input int line);
        logic [LW-1:0] v;
        v = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            v[8*b +: 8] = 8'((line * LINE_BYTES + b) & 255);
        end
        return v;
    endfunction

    state_t                state;
    logic [CNT_W-1:0]      counter;
    logic                  lat_write;
    logic                  lat_err;
    logic [IDX_W-1:0]      lat_idx;
    logic [LW-1:0]         lat_wdata;
    logic [LINE_BYTES-1:0] lat_be;

    logic [TAG_W-1:0]      req_line;
    logic                  req_oob;
    logic                  commit;
    logic                  unused_low_addr;
    logic [LW-1:0]         line_view [DEPTH_LINES];

    // Offset bits inside a line never select anything; compare with one spare bit so DEPTH_LINES never truncates.
    assign req_line        = in_req_addr[ADDR_W-1:OFF_W];
    assign req_oob         = {1'b0, req_line} >= (TAG_W+1)'(DEPTH_LINES);
    assign unused_low_addr = ^in_req_addr[OFF_W-1:0];

    assign out_req_ready = (state == IDLE) && !reset;
    assign commit        = (state == BUSY) && (counter == '0) && lat_write && !lat_err;

    // Storage holds its time-zero image across resets; only committed writes change it.
    for (genvar g = 0; g < DEPTH_LINES; g++) begin : g_line
        logic [LW-1:0] line_q = init_line(g);

        always_ff @(posedge clk) begin
            if (commit && (lat_idx == IDX_W'(g))) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (lat_be[b]) begin
                        line_q[8*b +: 8] <= lat_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign line_view[g] = line_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            lat_write      <= 1'b0;
            lat_err        <= 1'b0;
            lat_idx        <= '0;
            lat_wdata      <= '0;
            lat_be         <= '0;
            out_resp_valid <= 1'b0;
            out_resp_write <= 1'b0;
            out_resp_rdata <= '0;
            out_resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_req_valid && out_req_ready) begin
                        lat_write <= in_req_write;
                        lat_err   <= req_oob;
                        lat_idx   <= req_line[IDX_W-1:0];
                        lat_wdata <= in_req_wdata;
                        lat_be    <= in_req_byte_en;
                        counter   <= in_req_write ? CNT_W'(WRITE_LATENCY - 1)
                                                  : CNT_W'(READ_LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        out_resp_valid <= 1'b1;
                        out_resp_write <= lat_write;
                        out_resp_error <= lat_err;
                        out_resp_rdata <= (lat_write || lat_err) ? '0 : line_view[lat_idx];
                        state          <= RESP;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    if (in_resp_ready) begin
                        out_resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_MEM_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_read_count  <= '0;
            out_write_count <= '0;
        end else if ((state == RESP) && in_resp_ready && !lat_err) begin
            if (lat_write) begin
                out_write_count <= out_write_count + 32'd1;
            end else begin
                out_read_count <= out_read_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl: byte-array memory model plus per-cycle compare of the response channel.
`timescale 1ns/1ps
module tb_line_memory_ctrl;
    localparam int LB = 16;
    localparam int DL = 1024;
    localparam int RL = 10;
    localparam int WL = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_req_valid = 1'b0;
    logic         out_req_ready;
    logic         in_req_write = 1'b0;
    logic [31:0]  in_req_addr = '0;
    logic [127:0] in_req_wdata = '0;
    logic [15:0]  in_req_byte_en = '0;
    logic         out_resp_valid;
    logic         in_resp_ready = 1'b0;
    logic         out_resp_write;
    logic [127:0] out_resp_rdata;
    logic         out_resp_error;
`ifdef LINE_MEM_PERF_COUNTERS_EN
    logic [31:0]  read_count;
    logic [31:0]  write_count;
`endif

    always #5 clk = ~clk;

    line_memory_ctrl #(
        .LINE_BYTES(LB), .DEPTH_LINES(DL), .ADDR_W(32),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_req_valid(in_req_valid),
        .out_req_ready(out_req_ready),
        .in_req_write(in_req_write),
        .in_req_addr(in_req_addr),
        .in_req_wdata(in_req_wdata),
        .in_req_byte_en(in_req_byte_en),
        .out_resp_valid(out_resp_valid),
        .in_resp_ready(in_resp_ready),
        .out_resp_write(out_resp_write),
        .out_resp_rdata(out_resp_rdata),
        .out_resp_error(out_resp_error)
`ifdef LINE_MEM_PERF_COUNTERS_EN
        ,
        .out_read_count(read_count),
        .out_write_count(write_count)
`endif
    );

    logic [7:0]   ref_mem [LB*DL];
    int           total = 0;
    int           bad = 0;
    bit           run_checks = 0;
    bit           pending = 0;
    int           age = 0;
    int           lat_cur = RL;
    bit           m_wr = 0;
    int           m_line = 0;
    logic [127:0] m_wdata = '0;
    logic [15:0]  m_be = '0;
    bit           exp_write = 0;
    bit           exp_err = 0;
    logic [127:0] exp_rdata = '0;
    logic [127:0] got_rdata = '0;
    bit           got_err = 0;
    bit           got_write = 0;
    bit           seen_valid = 0;
    int           first_valid_age = -1;
    int unsigned  m_rd_cnt = 0;
    int unsigned  m_wr_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_line(input int line);
        logic [127:0] v;
        v = '0;
        for (int b = 0; b < LB; b++) v[8*b +: 8] = ref_mem[line*LB + b];
        return v;
    endfunction

    // Model timekeeping: age counts edges since acceptance; storage changes at the completion edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                pending  = 0;
                m_rd_cnt = 0;
                m_wr_cnt = 0;
            end else if (pending) begin
                if (age >= lat_cur) begin
                    if (in_resp_ready) begin
                        if (!exp_err) begin
                            if (m_wr) m_wr_cnt++;
                            else m_rd_cnt++;
                        end
                        pending = 0;
                    end
                end else begin
                    if (age == lat_cur - 1 && m_wr && !exp_err) begin
                        for (int b = 0; b < LB; b++)
                            if (m_be[b]) ref_mem[m_line*LB + b] = m_wdata[8*b +: 8];
                    end
                    age++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && run_checks) begin
                check("req_ready", out_req_ready, !pending);
                if (pending && age >= lat_cur) begin
                    check("resp_valid", out_resp_valid, 1'b1);
                    check("resp_write", out_resp_write, exp_write);
                    check("resp_error", out_resp_error, exp_err);
                    check("resp_rdata", out_resp_rdata, exp_rdata);
                    got_rdata = out_resp_rdata;
                    got_err   = out_resp_error;
                    got_write = out_resp_write;
                end else begin
                    check("resp_valid_idle", out_resp_valid, 1'b0);
                end
                if (pending && out_resp_valid && !seen_valid) begin
                    seen_valid      = 1;
                    first_valid_age = age;
                end
`ifdef LINE_MEM_PERF_COUNTERS_EN
                check("read_count", read_count, m_rd_cnt);
                check("write_count", write_count, m_wr_cnt);
`endif
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [127:0] wd,
                         input logic [15:0] be, input int hold, input bit abort);
        int guard;
        @(negedge clk);
        in_req_valid   = 1;
        in_req_write   = wr;
        in_req_addr    = addr;
        in_req_wdata   = wd;
        in_req_byte_en = be;
        in_resp_ready  = (hold == 0);
        @(posedge clk);
        #1;
        m_wr       = wr;
        m_line     = int'(addr >> 4);
        m_wdata    = wd;
        m_be       = be;
        exp_write  = wr;
        exp_err    = (addr >> 4) >= DL;
        exp_rdata  = (wr || exp_err) ? '0 : model_line(m_line);
        lat_cur    = wr ? WL : RL;
        age        = 0;
        seen_valid = 0;
        pending    = 1;
        // Scramble the request bus: the controller must use only what it latched.
        in_req_valid   = 0;
        in_req_write   = ~wr;
        in_req_addr    = $urandom;
        in_req_wdata   = {$urandom, $urandom, $urandom, $urandom};
        in_req_byte_en = 16'($urandom);
        if (abort) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            reset = 1;
            repeat (2) @(negedge clk);
            reset = 0;
            return;
        end
        guard = 0;
        while (pending && age < lat_cur && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (hold > 0) begin
            // An intruding write to line 0 offered while busy must never be taken.
            in_req_valid   = 1;
            in_req_write   = 1;
            in_req_addr    = 32'h0;
            in_req_wdata   = '1;
            in_req_byte_en = '1;
            repeat (hold) @(negedge clk);
            in_req_valid  = 0;
            in_resp_ready = 1;
        end
        guard = 0;
        while (pending && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("resp_handshake_timeout", pending, 1'b0);
        pending = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < LB*DL; k++) ref_mem[k] = 8'(k & 255);
        repeat (3) @(negedge clk);
        check("rst_req_ready", out_req_ready, 1'b0);
        check("rst_resp_valid", out_resp_valid, 1'b0);
        check("rst_resp_write", out_resp_write, 1'b0);
        check("rst_resp_rdata", out_resp_rdata, 128'h0);
        check("rst_resp_error", out_resp_error, 1'b0);
        reset = 0;
        @(negedge clk);
        run_checks = 1;

        issue(0, 32'h40, '0, '0, 0, 0);
        check("lit_rd40_latency", first_valid_age, 10);
        check("lit_rd40_data", got_rdata, 128'h4F4E4D4C4B4A49484746454443424140);
        check("lit_rd40_err", got_err, 1'b0);

        issue(1, 32'h40, {16{8'hAA}}, 16'h00FF, 0, 0);
        check("lit_wr40_write", got_write, 1'b1);
        check("lit_wr40_rdata", got_rdata, 128'h0);

        issue(0, 32'h40, '0, '0, 5, 0);
        check("lit_rd40_merged", got_rdata, 128'h4F4E4D4C4B4A4948AAAAAAAAAAAAAAAA);

        issue(0, 32'h4000, '0, '0, 0, 0);
        check("lit_oob_err", got_err, 1'b1);
        check("lit_oob_rdata", got_rdata, 128'h0);
        check("lit_oob_latency", first_valid_age, 10);

        issue(0, 32'h0, '0, '0, 0, 0);
        check("lit_rd0_data", got_rdata, 128'h0F0E0D0C0B0A09080706050403020100);

        issue(1, 32'h80, {16{8'h55}}, 16'hFFFF, 0, 1);
        issue(0, 32'h80, '0, '0, 0, 0);
        check("lit_rd80_after_abort", got_rdata, 128'h8F8E8D8C8B8A89888786858483828180);

        issue(1, 32'h84, {16{8'h77}}, 16'h0000, 0, 0);
        issue(0, 32'h80, '0, '0, 0, 0);
        check("lit_rd80_zero_be", got_rdata, 128'h8F8E8D8C8B8A89888786858483828180);

        issue(1, 32'h8C, 128'h00112233445566778899AABBCCDDEEFF, 16'h8001, 0, 0);
        issue(0, 32'h87, '0, '0, 0, 0);
        check("lit_rd80_edge_bytes", got_rdata, 128'h008E8D8C8B8A898887868584838281FF);

        issue(1, 32'h4000, {16{8'h33}}, 16'hFFFF, 0, 0);
        check("lit_oob_write_err", got_err, 1'b1);
        issue(0, 32'h0, '0, '0, 0, 0);
        check("lit_rd0_no_alias", got_rdata, 128'h0F0E0D0C0B0A09080706050403020100);
        issue(0, 32'hFFFF_FFF0, '0, '0, 0, 0);
        check("lit_top_addr_err", got_err, 1'b1);

        repeat (3) @(negedge clk);
`ifdef LINE_MEM_PERF_COUNTERS_EN
        check("lit_read_count", read_count, 32'd4);
        check("lit_write_count", write_count, 32'd2);
`endif
        run_checks = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
